// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and result encodings for the comparator family.
// The one-hot result codes are also used by the parallel comparator's bench.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } cmp_state_t;

   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_LT   = 3'b010;
   localparam logic [2:0] CMP_EQ   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

endpackage : cmp_pkg

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with a start/ready handshake.
// Flags are one-hot, registered and held until the next accepted start or clear.
module serial_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);

   localparam int CW = $clog2(WIDTH);

   cmp_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             decided_q, decided_d;
   logic             gt_int_q, gt_int_d;
   logic             lt_int_q, lt_int_d;
   logic [2:0]       res_q, res_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   logic             a_bit_s;
   logic             bit_diff_s;
   logic             first_hit_s;
   logic             decided_next_s;
   logic             gt_next_s;
   logic             lt_next_s;

   assign a_bit_s        = a_sh_q[WIDTH-1];
   assign bit_diff_s     = a_sh_q[WIDTH-1] ^ b_sh_q[WIDTH-1];
   assign first_hit_s    = ~decided_q & bit_diff_s;
   assign decided_next_s = decided_q | bit_diff_s;
   assign gt_next_s      = first_hit_s ? a_bit_s  : gt_int_q;
   assign lt_next_s      = first_hit_s ? ~a_bit_s : lt_int_q;

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      gt_int_d  = gt_int_q;
      lt_int_d  = lt_int_q;
      res_d     = res_q;
      valid_d   = valid_q;
      done_d    = 1'b0;

      if (clear) begin
         state_d = IDLE;
         valid_d = 1'b0;
         res_d   = CMP_NONE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d   = SHIFT;
                  a_sh_d    = a;
                  b_sh_d    = b;
                  cnt_d     = CW'(WIDTH - 1);
                  decided_d = 1'b0;
                  gt_int_d  = 1'b0;
                  lt_int_d  = 1'b0;
                  valid_d   = 1'b0;
                  res_d     = CMP_NONE;
               end else begin
                  state_d = state_q;
               end
            end
            SHIFT: begin
               a_sh_d    = {a_sh_q[WIDTH-2:0], 1'b0};
               b_sh_d    = {b_sh_q[WIDTH-2:0], 1'b0};
               cnt_d     = (cnt_q != {CW{1'b0}}) ? (cnt_q - CW'(1)) : cnt_q;
               decided_d = decided_next_s;
               gt_int_d  = gt_next_s;
               lt_int_d  = lt_next_s;
               // The exit edge already folds in the bit being examined this cycle.
               if ((cnt_q == {CW{1'b0}}) || (EARLY_EXIT && first_hit_s)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b1;
                  if (!decided_next_s) begin
                     res_d = CMP_EQ;
                  end else if (gt_next_s) begin
                     res_d = CMP_GT;
                  end else begin
                     res_d = CMP_LT;
                  end
               end else begin
                  state_d = SHIFT;
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
               res_d   = CMP_NONE;
            end
         endcase
      end

      ready_d = (state_d != SHIFT);
      busy_d  = (state_d == SHIFT);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_sh_q    <= {WIDTH{1'b0}};
         b_sh_q    <= {WIDTH{1'b0}};
         cnt_q     <= {CW{1'b0}};
         decided_q <= 1'b0;
         gt_int_q  <= 1'b0;
         lt_int_q  <= 1'b0;
         res_q     <= CMP_NONE;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         gt_int_q  <= gt_int_d;
         lt_int_q  <= lt_int_d;
         res_q     <= res_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign ready        = ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = valid_q;
   assign a_gt_b       = |(res_q & CMP_GT);
   assign a_lt_b       = |(res_q & CMP_LT);
   assign a_eq_b       = |(res_q & CMP_EQ);

endmodule : serial_magnitude_comparator

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for the serial comparator: one instance with fixed latency,
// one with early exit, sharing operands, clear and reset.
module tb_serial_magnitude_comparator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic [3:0] a, b;
   logic [1:0] start_v;
   logic [1:0] ready_v, busy_v, done_v, valid_v, gt_v, lt_v, eq_v;

   int nvec = 0;
   int nerr = 0;
   int n;

   always #5 clk = ~clk;

   serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .clear(clear), .a(a), .b(b),
      .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result_valid(valid_v[0]),
      .a_gt_b(gt_v[0]), .a_lt_b(lt_v[0]), .a_eq_b(eq_v[0]));

   serial_magnitude_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .clear(clear), .a(a), .b(b),
      .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result_valid(valid_v[1]),
      .a_gt_b(gt_v[1]), .a_lt_b(lt_v[1]), .a_eq_b(eq_v[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags(input int sel);
      return {gt_v[sel], lt_v[sel], eq_v[sel]};
   endfunction

   // Returns at the negedge following the accept edge.
   task automatic launch(input int sel, input logic [3:0] av, input logic [3:0] bv);
      @(negedge clk);
      a = av;
      b = bv;
      start_v[sel] = 1'b1;
      @(negedge clk);
      start_v[sel] = 1'b0;
   endtask

   task automatic wait_done(input int sel, input int n0, output int lat);
      lat = n0;
      while (!done_v[sel] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input int sel, input int lat,
                               input int exp_lat, input logic [2:0] exp_flags);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_flags"}, flags(sel), exp_flags);
      check({tag, "_valid_ready"}, {valid_v[sel], ready_v[sel], busy_v[sel]}, 3'b110);
   endtask

   initial begin
      rst_n   = 1'b0;
      clear   = 1'b0;
      start_v = 2'b00;
      a       = 4'd0;
      b       = 4'd0;
      #12;
      check("reset_dut0", {ready_v[0], busy_v[0], done_v[0], valid_v[0], flags(0)}, 7'b1000000);
      check("reset_dut1", {ready_v[1], busy_v[1], done_v[1], valid_v[1], flags(1)}, 7'b1000000);
      rst_n = 1'b1;

      // Fixed latency, a > b, then flags hold.
      launch(0, 4'd9, 4'd6);
      check("gt_busy", {busy_v[0], ready_v[0], done_v[0]}, 3'b100);
      wait_done(0, 0, n);
      check_result("gt9_6", 0, n, 4, 3'b100);
      @(negedge clk);
      check("done_pulse", done_v[0], 1'b0);
      repeat (3) @(negedge clk);
      check("gt_hold", {valid_v[0], flags(0)}, 4'b1100);

      // Equal operands in both modes.
      launch(0, 4'd5, 4'd5);
      wait_done(0, 0, n);
      check_result("eq5_ee0", 0, n, 4, 3'b001);
      launch(1, 4'd5, 4'd5);
      wait_done(1, 0, n);
      check_result("eq5_ee1", 1, n, 4, 3'b001);

      // Early exit at MSB and at LSB.
      launch(1, 4'd8, 4'd7);
      wait_done(1, 0, n);
      check_result("gt8_7_ee1", 1, n, 1, 3'b100);
      launch(1, 4'd2, 4'd3);
      wait_done(1, 0, n);
      check_result("lt2_3_ee1", 1, n, 4, 3'b010);

      // Start while busy is ignored; start during done cycle is accepted.
      launch(0, 4'd12, 4'd3);
      a = 4'd1;
      b = 4'd14;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, 1, n);
      check_result("busy_start_ignored", 0, n, 4, 3'b100);
      a = 4'd1;
      b = 4'd14;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("b2b_accept", {valid_v[0], done_v[0], busy_v[0], flags(0)}, 6'b001000);
      wait_done(0, 0, n);
      check_result("b2b_lt1_14", 0, n, 4, 3'b010);

      // Async reset mid-shift.
      launch(0, 4'd9, 4'd6);
      rst_n = 1'b0;
      #1;
      check("async_rst", {ready_v[0], busy_v[0], done_v[0], valid_v[0], flags(0)}, 7'b1000000);
      #1;
      rst_n = 1'b1;

      // Clear and start together in IDLE: clear wins.
      @(negedge clk);
      a = 4'd3;
      b = 4'd1;
      start_v[0] = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      clear = 1'b0;
      check("clr_start", {ready_v[0], busy_v[0], done_v[0], valid_v[0]}, 4'b1000);
      repeat (5) @(negedge clk);
      check("clr_start_nodone", {done_v[0], valid_v[0], busy_v[0]}, 3'b000);

      // Clear mid-shift aborts, clear in DONE drops flags.
      launch(0, 4'd3, 4'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_shift", {ready_v[0], busy_v[0], valid_v[0], flags(0)}, 6'b100000);
      launch(0, 4'd3, 4'd1);
      wait_done(0, 0, n);
      check_result("gt3_1", 0, n, 4, 3'b100);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_done", {ready_v[0], valid_v[0], flags(0)}, 5'b10000);

      // Exhaustive sweep against a behavioural model.
      for (int sel = 0; sel < 2; sel++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               logic [3:0] av, bv;
               logic [2:0] ef;
               int el;
               av = 4'(ai);
               bv = 4'(bi);
               ef = (av > bv) ? 3'b100 : ((av < bv) ? 3'b010 : 3'b001);
               el = 4;
               if (sel == 1 && av != bv) begin
                  for (int i = 0; i < 4; i++) begin
                     if (av[i] != bv[i]) el = 4 - i;
                  end
               end
               launch(sel, av, bv);
               wait_done(sel, 0, n);
               check_result($sformatf("sweep_ee%0d_%0d_%0d", sel, ai, bi), sel, n, el, ef);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_serial_magnitude_comparator
